execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 194 +++++++++++++++++++
 tb/tb_execute_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// RV32I execute stage: ALU, branch resolution and the EX/MEM pipeline register.
// A taken transfer raises a one-cycle redirect and squashes the next ID/EX entry.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic [31:0] PC_pype1,
    input  logic [31:0] PCp4_pype1,
    input  logic [31:0] read_data1_pype,
    input  logic [31:0] read_data2_pype,
    input  logic [31:0] Imm_pype,
    input  logic [3:0]  for_ALU_c,
    input  logic [6:0]  ALU_command_7,
    input  logic [4:0]  WReg_pype,
    input  logic        RegWrite_pype1,
    input  logic [1:0]  MemtoReg_pype1,
    input  logic [1:0]  MemRW_pype1,
    input  logic [2:0]  MemBranch_pype,
    input  logic [2:0]  ALU_control_pype,
    input  logic [2:0]  ALU_Src_pype,
    output logic [31:0] ALU_result_pype2,
    output logic [31:0] store_data_pype2,
    output logic [31:0] PCp4_pype2,
    output logic [4:0]  WReg_pype2,
    output logic        RegWrite_pype2,
    output logic [1:0]  MemtoReg_pype2,
    output logic [1:0]  MemRW_pype2,
    output logic [2:0]  funct3_pype2,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] pcp4;
        logic [4:0]  wreg;
        logic        regwrite;
        logic [1:0]  memtoreg;
        logic [1:0]  memrw;
        logic [2:0]  funct3;
    } ex_mem_t;

    localparam logic [2:0] CTL_ALU   = 3'b000;
    localparam logic [2:0] CTL_LUI   = 3'b010;
    localparam logic [2:0] CTL_LOAD  = 3'b100;
    localparam logic [2:0] CTL_STORE = 3'b101;

    localparam logic [2:0] BR_EQ   = 3'b001;
    localparam logic [2:0] BR_NE   = 3'b010;
    localparam logic [2:0] BR_LT   = 3'b011;
    localparam logic [2:0] BR_GE   = 3'b100;
    localparam logic [2:0] BR_JALR = 3'b110;
    localparam logic [2:0] BR_JAL  = 3'b111;

    ex_mem_t     ex_q, ex_d;
    logic        redir_q, redir_d;
    logic [31:0] rpc_q, rpc_d;
    logic        squash_q, squash_d;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [31:0] addr_sum;
    logic        is_sub;
    logic        lt_s;
    logic        lt_u;
    logic        br_lt;
    logic        taken;
    logic [31:0] target;
    logic        unused_f7;

    assign unused_f7 = ^{ALU_command_7[6], ALU_command_7[4:0]};

    // Operand selection
    always_comb begin
        op_a = read_data1_pype;
        if (ALU_Src_pype[2]) begin
            op_a = PC_pype1;
        end else if (ALU_Src_pype == 3'b000) begin
            op_a = 32'd0;
        end
        op_b = (ALU_Src_pype[1:0] == 2'b11) ? read_data2_pype : Imm_pype;
    end

    assign shamt    = op_b[4:0];
    assign addr_sum = read_data1_pype + Imm_pype;
    assign is_sub   = for_ALU_c[3] && (ALU_Src_pype == 3'b011);

    always_comb begin
        alu_res = op_a + op_b;
        if (ALU_control_pype == CTL_LOAD || ALU_control_pype == CTL_STORE) begin
            alu_res = addr_sum;
        end else if (ALU_control_pype == CTL_LUI) begin
            alu_res = Imm_pype;
        end else if (ALU_control_pype == CTL_ALU) begin
            case (for_ALU_c[2:0])
                3'b000: alu_res = is_sub ? (op_a - op_b) : (op_a + op_b);
                3'b001: alu_res = op_a << shamt;
                3'b010: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
                3'b011: alu_res = {31'd0, op_a < op_b};
                3'b100: alu_res = op_a ^ op_b;
                3'b101: begin
                    if (ALU_command_7[5]) begin
                        alu_res = $unsigned($signed(op_a) >>> shamt);
                    end else begin
                        alu_res = op_a >> shamt;
                    end
                end
                3'b110: alu_res = op_a | op_b;
                3'b111: alu_res = op_a & op_b;
                default: alu_res = op_a + op_b;
            endcase
        end
    end

    // Branch resolution on the raw register operands
    assign lt_s  = $signed(read_data1_pype) < $signed(read_data2_pype);
    assign lt_u  = read_data1_pype < read_data2_pype;
    assign br_lt = for_ALU_c[1] ? lt_u : lt_s;

    always_comb begin
        taken = 1'b0;
        case (MemBranch_pype)
            BR_EQ:   taken = (read_data1_pype == read_data2_pype);
            BR_NE:   taken = (read_data1_pype != read_data2_pype);
            BR_LT:   taken = br_lt;
            BR_GE:   taken = !br_lt;
            BR_JALR: taken = 1'b1;
            BR_JAL:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        target = PC_pype1 + Imm_pype;
        if (MemBranch_pype == BR_JALR) begin
            target = addr_sum & ~32'd1;
        end
    end

    // Next-state selection: nop > keep > squash > normal
    always_comb begin
        ex_d     = ex_q;
        redir_d  = 1'b0;
        rpc_d    = rpc_q;
        squash_d = squash_q;
        if (nop || (!keep && squash_q)) begin
            ex_d          = '0;
            ex_d.pcp4     = ex_q.pcp4;
            squash_d      = 1'b0;
        end else if (!keep) begin
            ex_d.alu      = alu_res;
            ex_d.sdata    = read_data2_pype;
            ex_d.pcp4     = PCp4_pype1;
            ex_d.wreg     = WReg_pype;
            ex_d.regwrite = RegWrite_pype1 && (WReg_pype != 5'd0);
            ex_d.memtoreg = MemtoReg_pype1;
            ex_d.memrw    = MemRW_pype1;
            ex_d.funct3   = for_ALU_c[2:0];
            redir_d       = taken;
            rpc_d         = taken ? target : rpc_q;
            squash_d      = taken;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q     <= '0;
            redir_q  <= 1'b0;
            rpc_q    <= 32'h0;
            squash_q <= 1'b0;
        end else begin
            ex_q     <= ex_d;
            redir_q  <= redir_d;
            rpc_q    <= rpc_d;
            squash_q <= squash_d;
        end
    end

    assign ALU_result_pype2 = ex_q.alu;
    assign store_data_pype2 = ex_q.sdata;
    assign PCp4_pype2       = ex_q.pcp4;
    assign WReg_pype2       = ex_q.wreg;
    assign RegWrite_pype2   = ex_q.regwrite;
    assign MemtoReg_pype2   = ex_q.memtoreg;
    assign MemRW_pype2      = ex_q.memrw;
    assign funct3_pype2     = ex_q.funct3;
    assign redirect         = redir_q;
    assign redirect_pc      = rpc_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a reference model predicts each edge,
// directed cases pin the key ALU/branch/keep/squash/reset behaviours.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        keep, nop;
    logic [31:0] PC_pype1, PCp4_pype1, read_data1_pype, read_data2_pype, Imm_pype;
    logic [3:0]  for_ALU_c;
    logic [6:0]  ALU_command_7;
    logic [4:0]  WReg_pype;
    logic        RegWrite_pype1;
    logic [1:0]  MemtoReg_pype1, MemRW_pype1;
    logic [2:0]  MemBranch_pype, ALU_control_pype, ALU_Src_pype;
    logic [31:0] ALU_result_pype2, store_data_pype2, PCp4_pype2;
    logic [4:0]  WReg_pype2;
    logic        RegWrite_pype2;
    logic [1:0]  MemtoReg_pype2, MemRW_pype2;
    logic [2:0]  funct3_pype2;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst(rst), .keep(keep), .nop(nop),
        .PC_pype1(PC_pype1), .PCp4_pype1(PCp4_pype1),
        .read_data1_pype(read_data1_pype), .read_data2_pype(read_data2_pype),
        .Imm_pype(Imm_pype), .for_ALU_c(for_ALU_c), .ALU_command_7(ALU_command_7),
        .WReg_pype(WReg_pype), .RegWrite_pype1(RegWrite_pype1),
        .MemtoReg_pype1(MemtoReg_pype1), .MemRW_pype1(MemRW_pype1),
        .MemBranch_pype(MemBranch_pype), .ALU_control_pype(ALU_control_pype),
        .ALU_Src_pype(ALU_Src_pype),
        .ALU_result_pype2(ALU_result_pype2), .store_data_pype2(store_data_pype2),
        .PCp4_pype2(PCp4_pype2), .WReg_pype2(WReg_pype2),
        .RegWrite_pype2(RegWrite_pype2), .MemtoReg_pype2(MemtoReg_pype2),
        .MemRW_pype2(MemRW_pype2), .funct3_pype2(funct3_pype2),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic [31:0] alu, sd, pcp4, rpc;
        logic [4:0]  wreg;
        logic        rw, redir;
        logic [1:0]  mtr, mrw;
        logic [2:0]  f3;
    } exp_t;

    exp_t m;
    logic m_sq;
    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alu"}, ALU_result_pype2, 32'd0);
        chk({tag, "_sd"}, store_data_pype2, 32'd0);
        chk({tag, "_pcp4"}, PCp4_pype2, 32'd0);
        chk({tag, "_wreg"}, {27'd0, WReg_pype2}, 32'd0);
        chk({tag, "_rw"}, {31'd0, RegWrite_pype2}, 32'd0);
        chk({tag, "_mtr"}, {30'd0, MemtoReg_pype2}, 32'd0);
        chk({tag, "_mrw"}, {30'd0, MemRW_pype2}, 32'd0);
        chk({tag, "_f3"}, {29'd0, funct3_pype2}, 32'd0);
        chk({tag, "_redir"}, {31'd0, redirect}, 32'd0);
        chk({tag, "_rpc"}, redirect_pc, 32'd0);
    endtask

    function automatic logic [31:0] ref_alu();
        logic [31:0] a, b;
        logic [4:0] sh;
        a = ALU_Src_pype[2] ? PC_pype1 :
            (ALU_Src_pype == 3'b000 ? 32'd0 : read_data1_pype);
        b = (ALU_Src_pype[1:0] == 2'b11) ? read_data2_pype : Imm_pype;
        sh = b[4:0];
        if (ALU_control_pype == 3'b100 || ALU_control_pype == 3'b101)
            return read_data1_pype + Imm_pype;
        if (ALU_control_pype == 3'b010) return Imm_pype;
        if (ALU_control_pype != 3'b000) return a + b;
        case (for_ALU_c[2:0])
            3'd0: return (for_ALU_c[3] && ALU_Src_pype == 3'b011) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return ALU_command_7[5] ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_taken();
        logic lt;
        lt = for_ALU_c[1] ? (read_data1_pype < read_data2_pype)
                          : ($signed(read_data1_pype) < $signed(read_data2_pype));
        case (MemBranch_pype)
            3'b001: return read_data1_pype == read_data2_pype;
            3'b010: return read_data1_pype != read_data2_pype;
            3'b011: return lt;
            3'b100: return !lt;
            3'b110, 3'b111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_tgt();
        if (MemBranch_pype == 3'b110) return (read_data1_pype + Imm_pype) & ~32'd1;
        return PC_pype1 + Imm_pype;
    endfunction

    function automatic exp_t bubble(input exp_t s);
        exp_t r;
        r = s;
        r.alu = 0; r.sd = 0; r.wreg = 0; r.rw = 0;
        r.mtr = 0; r.mrw = 0; r.f3 = 0; r.redir = 0;
        return r;
    endfunction

    task automatic model_clear();
        m = '{alu: 0, sd: 0, pcp4: 0, rpc: 0, wreg: 0, rw: 0,
              redir: 0, mtr: 0, mrw: 0, f3: 0};
        m_sq = 1'b0;
    endtask

    task automatic tick();
        exp_t nx, e;
        logic tk;
        nx = m;
        if (nop) begin
            nx = bubble(m); m_sq = 1'b0;
        end else if (keep) begin
            nx.redir = 1'b0;
        end else if (m_sq) begin
            nx = bubble(m); m_sq = 1'b0;
        end else begin
            tk = ref_taken();
            nx.alu = ref_alu(); nx.sd = read_data2_pype; nx.pcp4 = PCp4_pype1;
            nx.wreg = WReg_pype; nx.rw = RegWrite_pype1 && (WReg_pype != 0);
            nx.mtr = MemtoReg_pype1; nx.mrw = MemRW_pype1; nx.f3 = for_ALU_c[2:0];
            nx.redir = tk;
            if (tk) nx.rpc = ref_tgt();
            m_sq = tk;
        end
        m = nx;
        q.push_back(nx);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("alu", ALU_result_pype2, e.alu);
        chk("sd", store_data_pype2, e.sd);
        chk("pcp4", PCp4_pype2, e.pcp4);
        chk("wreg", {27'd0, WReg_pype2}, {27'd0, e.wreg});
        chk("rw", {31'd0, RegWrite_pype2}, {31'd0, e.rw});
        chk("mtr", {30'd0, MemtoReg_pype2}, {30'd0, e.mtr});
        chk("mrw", {30'd0, MemRW_pype2}, {30'd0, e.mrw});
        chk("f3", {29'd0, funct3_pype2}, {29'd0, e.f3});
        chk("redir", {31'd0, redirect}, {31'd0, e.redir});
        if (e.redir) chk("rpc", redirect_pc, e.rpc);
    endtask

    task automatic clr();
        keep = 0; nop = 0;
        PC_pype1 = 0; PCp4_pype1 = 0; read_data1_pype = 0;
        read_data2_pype = 0; Imm_pype = 0; for_ALU_c = 0;
        ALU_command_7 = 0; WReg_pype = 0; RegWrite_pype1 = 0;
        MemtoReg_pype1 = 0; MemRW_pype1 = 0; MemBranch_pype = 0;
        ALU_control_pype = 0; ALU_Src_pype = 0;
    endtask

    task automatic addi(input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] im);
        clr();
        read_data1_pype = r1; Imm_pype = im; ALU_Src_pype = 3'b010;
        WReg_pype = rd; RegWrite_pype1 = 1; PCp4_pype1 = 32'h44; MemRW_pype1 = 2'b01;
    endtask

    task automatic do_reset(input string tag);
        rst = 0;
        #1;
        chk_zero(tag);
        model_clear();
        #1;
        rst = 1;
    endtask

    initial begin
        clr();
        model_clear();
        rst = 0;
        @(posedge clk);
        #1;
        chk_zero("rst");
        rst = 1;

        addi(5'd1, 32'd5, -32'sd3);
        tick();
        chk("addi_res", ALU_result_pype2, 32'd2);
        chk("addi_rw", {31'd0, RegWrite_pype2}, 32'd1);

        clr();
        read_data1_pype = 32'h8000_0000; read_data2_pype = 32'd4;
        ALU_Src_pype = 3'b011; for_ALU_c = 4'b1000; WReg_pype = 2; RegWrite_pype1 = 1;
        tick();
        chk("sub", ALU_result_pype2, 32'h7FFF_FFFC);
        for_ALU_c = 4'b0101; ALU_command_7 = 7'h20;
        tick();
        chk("sra", ALU_result_pype2, 32'hF800_0000);

        clr();
        PC_pype1 = 32'h100; Imm_pype = 32'h20; read_data1_pype = 7;
        read_data2_pype = 7; MemBranch_pype = 3'b001;
        tick();
        chk("beq_redir", {31'd0, redirect}, 32'd1);
        chk("beq_pc", redirect_pc, 32'h120);
        addi(5'd3, 32'd1, 32'd1);
        tick();
        chk("beq_sq_redir", {31'd0, redirect}, 32'd0);
        chk("beq_sq_rw", {31'd0, RegWrite_pype2}, 32'd0);
        chk("beq_sq_mrw", {30'd0, MemRW_pype2}, 32'd0);
        tick();
        chk("post_sq_rw", {31'd0, RegWrite_pype2}, 32'd1);

        clr();
        read_data1_pype = 32'hFFFF_FFFF; read_data2_pype = 1; PC_pype1 = 32'h200;
        Imm_pype = 32'h8; MemBranch_pype = 3'b011; for_ALU_c = 4'b0110;
        tick();
        chk("bltu", {31'd0, redirect}, 32'd0);
        for_ALU_c = 4'b0100;
        tick();
        chk("blt", {31'd0, redirect}, 32'd1);
        chk("blt_pc", redirect_pc, 32'h208);
        tick();
        clr();
        read_data1_pype = 32'h203; MemBranch_pype = 3'b110;
        WReg_pype = 1; RegWrite_pype1 = 1; PCp4_pype1 = 32'h304;
        tick();
        chk("jalr_pc", redirect_pc, 32'h202);
        clr();
        tick();

        clr();
        PC_pype1 = 32'h400; Imm_pype = 32'h10; MemBranch_pype = 3'b111;
        WReg_pype = 1; RegWrite_pype1 = 1; PCp4_pype1 = 32'h404;
        tick();
        chk("jal_redir", {31'd0, redirect}, 32'd1);
        chk("jal_pc", redirect_pc, 32'h410);
        addi(5'd5, 32'd9, 32'd1);
        keep = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("keep_redir", {31'd0, redirect}, 32'd0);
            chk("keep_pcp4", PCp4_pype2, 32'h404);
        end
        keep = 0;
        tick();
        chk("keep_sq_rw", {31'd0, RegWrite_pype2}, 32'd0);
        tick();
        chk("keep_after", ALU_result_pype2, 32'd10);

        addi(5'd0, 32'd3, 32'd3);
        tick();
        chk("x0_rw", {31'd0, RegWrite_pype2}, 32'd0);

        clr();
        MemBranch_pype = 3'b111; PC_pype1 = 32'h40;
        tick();
        do_reset("midsq");
        addi(5'd6, 32'd20, 32'd2);
        tick();
        chk("postrst_rw", {31'd0, RegWrite_pype2}, 32'd1);
        chk("postrst_alu", ALU_result_pype2, 32'd22);

        nop = 1;
        tick();
        chk("nop_rw", {31'd0, RegWrite_pype2}, 32'd0);
        chk("nop_pcp4", PCp4_pype2, 32'h44);

        for (int i = 0; i < 300; i++) begin
            PC_pype1 = $urandom & ~32'd3;
            PCp4_pype1 = PC_pype1 + 4;
            read_data1_pype = $urandom;
            read_data2_pype = ($urandom_range(0, 3) == 0) ? read_data1_pype : $urandom;
            Imm_pype = $urandom;
            for_ALU_c = 4'($urandom);
            ALU_command_7 = 7'($urandom);
            WReg_pype = 5'($urandom);
            RegWrite_pype1 = 1'($urandom);
            MemtoReg_pype1 = 2'($urandom);
            MemRW_pype1 = 2'($urandom);
            MemBranch_pype = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            ALU_control_pype = 3'($urandom);
            ALU_Src_pype = 3'($urandom);
            keep = ($urandom_range(0, 7) == 0);
            nop = ($urandom_range(0, 15) == 0);
            tick();
            if ($urandom_range(0, 63) == 0) do_reset("rnd_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
